lsu_ctrl: RTL and testbench

Load/store controller sitting between the core's memory stage and the 256-word data memory. It accepts one load or store request at a time over a valid/ready handshake and issues only word-aligned, full-word accesses (mask 3'b010) to the data memory. It performs byte/half-word lane extraction, sign/zero extension, and read-modify-write merging itself. Misaligned, out-of-range and illegal-mask requests are rejected with an error response and make no memory access.

---
 rtl/lsu_ctrl_if.sv | 37 +++
 rtl/lsu_ctrl.sv | 141 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Load/store request/response handshake and data-memory bus.
// slave: controller side; master: core pipeline plus memory side.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_mask;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        mem_wr;
  logic        mem_rd;
  logic [2:0]  mask;
  logic [31:0] rd_data;

  modport slave (
    input  req_valid, req_we, req_mask,
    input  req_addr, req_wdata, rd_data,
    output req_ready, resp_valid,
    output resp_rdata, resp_err,
    output addr, wr_data, mem_wr,
    output mem_rd, mask
  );

  modport master (
    output req_valid, req_we, req_mask,
    output req_addr, req_wdata, rd_data,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err,
    input  addr, wr_data, mem_wr,
    input  mem_rd, mask
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, word-only memory
// accesses, lane extract/extend and read-modify-write merge here.
module lsu_ctrl #(
  parameter int MEM_WORDS = 256
) (
  input logic      clk,
  input logic      rst_n,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, RD, WR, RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      st, st_n;
  req_t        rq;
  logic        err_q;
  logic [31:0] buf_q;
  logic        err_c;
  logic [31:0] merged;
  logic [31:0] ext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_addr;

  always_comb begin
    err_c = 1'b0;
    unique case (bus.req_mask)
      3'b011, 3'b110, 3'b111: err_c = 1'b1;
      3'b001, 3'b101: err_c = bus.req_addr[0];
      3'b010: err_c = |bus.req_addr[1:0];
      default: err_c = 1'b0;
    endcase
    if (bus.req_we && bus.req_mask[2])
      err_c = 1'b1;
    if ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS))
      err_c = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      rq    <= '0;
      err_q <= 1'b0;
      buf_q <= '0;
    end else begin
      st <= st_n;
      if (st == IDLE && bus.req_valid) begin
        rq.we    <= bus.req_we;
        rq.mask  <= bus.req_mask;
        rq.addr  <= bus.req_addr;
        rq.wdata <= bus.req_wdata;
        err_q    <= err_c;
      end
      if (st == RD)
        buf_q <= bus.rd_data;
    end
  end

  assign word_addr = {rq.addr[31:2], 2'b00};
  assign byte_v = buf_q[{rq.addr[1:0], 3'b000} +: 8];
  assign half_v = rq.addr[1] ? buf_q[31:16]
                             : buf_q[15:0];

  // Sub-word stores patch only the addressed lane of the read word.
  always_comb begin
    merged = buf_q;
    unique case (rq.mask[1:0])
      2'b00:
        merged[{rq.addr[1:0], 3'b000} +: 8] = rq.wdata[7:0];
      2'b01:
        if (rq.addr[1])
          merged[31:16] = rq.wdata[15:0];
        else
          merged[15:0] = rq.wdata[15:0];
      default: merged = rq.wdata;
    endcase
  end

  always_comb begin
    unique case (rq.mask)
      3'b000:  ext = {{24{byte_v[7]}}, byte_v};
      3'b100:  ext = {24'h0, byte_v};
      3'b001:  ext = {{16{half_v[15]}}, half_v};
      3'b101:  ext = {16'h0, half_v};
      default: ext = buf_q;
    endcase
  end

  always_comb begin
    st_n           = st;
    bus.req_ready  = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.addr       = '0;
    bus.wr_data    = '0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    bus.mask       = 3'b010;
    unique case (st)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (err_c)
            st_n = RESP;
          else if (bus.req_we && bus.req_mask == 3'b010)
            st_n = WR;
          else
            st_n = RD;
        end
      end
      RD: begin
        bus.mem_rd = 1'b1;
        bus.addr   = word_addr;
        st_n       = rq.we ? WR : RESP;
      end
      WR: begin
        bus.mem_wr  = 1'b1;
        bus.addr    = word_addr;
        bus.wr_data = merged;
        st_n        = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        bus.resp_rdata = (err_q || rq.we) ? '0 : ext;
        st_n           = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl with a byte-addressed reference
// memory; directed plan steps followed by randomized requests.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if bus();

  lsu_ctrl #(.MEM_WORDS(256)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] mem [256];
  logic [7:0]  ref_b [1024];

  assign bus.rd_data = mem[bus.addr[9:2]];

  always @(negedge clk)
    if (bus.mem_wr)
      mem[bus.addr[9:2]] <= bus.wr_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(logic [2:0] m);
    if (m[1:0] == 2'b00) return 1;
    if (m[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_err(bit we, logic [2:0] m,
                                 logic [31:0] a);
    if (m == 3'b011 || m[2:1] == 2'b11) return 1;
    if (we && m[2]) return 1;
    if (a % acc_size(m) != 0) return 1;
    if (a >= 1024) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_word(int idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2],
            ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] m,
                                           logic [31:0] a);
    int sz;
    logic [31:0] v;
    sz = acc_size(m);
    v = 0;
    for (int i = 0; i < sz; i++)
      v = v | (32'(ref_b[a+i]) << (8*i));
    if (!m[2] && sz == 1 && v[7]) v = v | 32'hFFFF_FF00;
    if (!m[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic ref_store(logic [2:0] m, logic [31:0] a,
                           logic [31:0] d);
    for (int i = 0; i < acc_size(m); i++)
      ref_b[a+i] = d[8*i +: 8];
  endtask

  // Called and returns at posedge+1 with the DUT idle.
  task automatic do_req(input bit we, input logic [2:0] m,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        output logic [31:0] got);
    bit e, saw_rd, saw_wr;
    int exp_lat, lat;
    logic [31:0] exp_r;
    e = ref_err(we, m, a);
    exp_lat = e ? 1 : (!we ? 2 : (m == 3'b010 ? 2 : 3));
    exp_r = (e || we) ? 32'h0 : ref_load(m, a);
    chk("ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_mask  = m;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_mask  = 3'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    lat = 1;
    saw_rd = 0;
    saw_wr = 0;
    while (!bus.resp_valid && lat < 10) begin
      if (bus.mem_rd) saw_rd = 1;
      if (bus.mem_wr) saw_wr = 1;
      if (bus.mem_rd || bus.mem_wr)
        chk("mem_addr", bus.addr, {a[31:2], 2'b00});
      chk("ready_busy", 32'(bus.req_ready), 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("ready_resp", 32'(bus.req_ready), 0);
    chk("resp_rdata", bus.resp_rdata, exp_r);
    chk("resp_err", 32'(bus.resp_err), 32'(e));
    chk("saw_rd", 32'(saw_rd),
        32'(!e && !(we && m == 3'b010)));
    chk("saw_wr", 32'(saw_wr), 32'(!e && we));
    if (!e && we) ref_store(m, a, d);
    chk("mem_word", mem[a[9:2]], ref_word(int'(a[9:2])));
    got = bus.resp_rdata;
    @(posedge clk); #1;
    chk("resp_pulse", 32'(bus.resp_valid), 0);
  endtask

  initial begin
    logic [31:0] g, w, a;
    logic [2:0] ml [8];
    logic [31:0] exp_q [$];
    logic [2:0] bm [4];
    logic [31:0] ba [4];
    int n_acc, n_resp, mi;
    bit rdy, outstanding;

    ml = '{3'b000, 3'b001, 3'b010, 3'b100,
           3'b101, 3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      mem[i] = w;
      for (int k = 0; k < 4; k++)
        ref_b[4*i+k] = w[8*k +: 8];
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_mask  = 3'b010;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_mem_rd", 32'(bus.mem_rd), 0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 0);
    chk("rst_resp", 32'(bus.resp_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(bus.req_ready), 1);

    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, g);
    do_req(0, 3'b010, 32'h10, 32'h0, g);
    chk("lw_const", g, 32'hDEADBEEF);
    do_req(1, 3'b000, 32'h11, 32'h5A, g);
    chk("sb_merge", mem[4], 32'hDEAD5AEF);
    do_req(0, 3'b000, 32'h13, 32'h0, g);
    chk("lb_const", g, 32'hFFFFFFDE);
    do_req(0, 3'b100, 32'h13, 32'h0, g);
    chk("lbu_const", g, 32'h000000DE);
    do_req(0, 3'b001, 32'h12, 32'h0, g);
    chk("lh_const", g, 32'hFFFFDEAD);

    do_req(1, 3'b001, 32'h21, 32'h1234, g);
    do_req(0, 3'b010, 32'h400, 32'h0, g);
    do_req(0, 3'b011, 32'h10, 32'h0, g);

    bm = '{3'b010, 3'b100, 3'b001, 3'b010};
    ba = '{32'h10, 32'h13, 32'h12, 32'h40};
    n_acc = 0;
    n_resp = 0;
    outstanding = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_mask  = bm[0];
    bus.req_addr  = ba[0];
    for (int c = 0; c < 60 && n_resp < 4; c++) begin
      rdy = bus.req_ready;
      @(posedge clk); #1;
      if (rdy && bus.req_valid) begin
        exp_q.push_back(ref_load(bm[n_acc], ba[n_acc]));
        n_acc++;
        outstanding = 1;
        if (n_acc < 4) begin
          bus.req_mask = bm[n_acc];
          bus.req_addr = ba[n_acc];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      if (outstanding)
        chk("b2b_ready", 32'(bus.req_ready), 0);
      if (bus.resp_valid) begin
        chk("b2b_rdata", bus.resp_rdata,
            exp_q.size() > 0 ? exp_q.pop_front() : 32'hX);
        n_resp++;
        outstanding = 0;
      end
    end
    bus.req_valid = 1'b0;
    chk("b2b_acc", n_acc, 4);
    chk("b2b_resp", n_resp, 4);
    repeat (3) begin
      @(posedge clk); #1;
      chk("b2b_extra", 32'(bus.resp_valid), 0);
    end

    w = mem[8];
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_mask  = 3'b000;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hA5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rd_state", 32'(bus.mem_rd), 1);
    rst_n = 1'b0;
    #1;
    chk("rd_rst_ready", 32'(bus.req_ready), 1);
    chk("rd_rst_mem_rd", 32'(bus.mem_rd), 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rd_rst_resp", 32'(bus.resp_valid), 0);
      chk("rd_rst_wr", 32'(bus.mem_wr), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rd_rst_word", mem[8], w);
    chk("rd_rst_idle", 32'(bus.req_ready), 1);

    w = mem[9];
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h24;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("wr_state", 32'(bus.mem_wr), 1);
    rst_n = 1'b0;
    #1;
    chk("wr_rst_mem_wr", 32'(bus.mem_wr), 0);
    @(posedge clk); #1;
    chk("wr_rst_resp", 32'(bus.resp_valid), 0);
    chk("wr_rst_word", mem[9], w);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("wr_rst_idle", 32'(bus.req_ready), 1);

    for (int n = 0; n < 80; n++) begin
      mi = $urandom_range(0, 9);
      if (mi > 7) mi = 2;
      if ($urandom_range(0, 9) == 0)
        a = $urandom;
      else
        a = 32'($urandom_range(0, 255));
      do_req(1'($urandom), ml[mi], a, $urandom, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
